mem_arbiter16: RTL and testbench



---
 rtl/mem_arbiter16.sv | 125 ++++++++++++
 tb/tb_mem_arbiter16.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter16.sv
// Two-master arbiter for the 16-bit memory port: fixed CPU priority with a
// DMA starvation counter, and read data steered back to the issuing master.
module mem_arbiter16 #(
    parameter int DMA_WAIT_MAX = 3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic        cpu_lock,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_stall,
    output logic        cpu_rvalid,
    output logic [15:0] cpu_rdata,
    input  logic        dma_req,
    input  logic        dma_wr,
    input  logic [15:0] dma_addr,
    input  logic [15:0] dma_wdata,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic [15:0] dma_rdata,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        mem_OEb,
    output logic        mem_WRb
);

    generate
        if (DMA_WAIT_MAX < 1 || DMA_WAIT_MAX > 15) begin : g_bad_wait_max
            $error("mem_arbiter16: DMA_WAIT_MAX must be in 1..15");
        end
    endgenerate

    localparam logic [3:0] WAIT_MAX  = 4'(DMA_WAIT_MAX);
    localparam logic [1:0] OWN_NONE  = 2'd0;
    localparam logic [1:0] OWN_CPU   = 2'd1;
    localparam logic [1:0] OWN_DMA   = 2'd2;

    logic [3:0]  wait_cnt;
    logic [3:0]  wait_next;
    logic [1:0]  rd_owner;
    logic [1:0]  owner_next;
    logic [15:0] cpu_rdata_hold;
    logic [15:0] dma_rdata_hold;
    logic        dma_force;

    // Grant decision and memory-side muxing from the current requests.
    always_comb begin
        dma_force = (wait_cnt >= WAIT_MAX) & ~cpu_lock;
        dma_gnt   = dma_req & (~cpu_req | dma_force);
        cpu_gnt   = cpu_req & ~dma_gnt;
        cpu_stall = cpu_req & ~cpu_gnt;
        mem_OEb   = ~((cpu_gnt & ~cpu_wr) | (dma_gnt & ~dma_wr));
        mem_WRb   = ~((cpu_gnt & cpu_wr) | (dma_gnt & dma_wr));
        if (cpu_gnt) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (dma_gnt) begin
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end else begin
            mem_addr  = 16'h0000;
            mem_wdata = 16'h0000;
        end
    end

    // Next-state for the starvation counter and the read-return owner.
    always_comb begin
        if (dma_req & ~dma_gnt) begin
            wait_next = (wait_cnt == 4'd15) ? 4'd15 : wait_cnt + 4'd1;
        end else begin
            wait_next = 4'd0;
        end
        if (cpu_gnt & ~cpu_wr) begin
            owner_next = OWN_CPU;
        end else if (dma_gnt & ~dma_wr) begin
            owner_next = OWN_DMA;
        end else begin
            owner_next = OWN_NONE;
        end
    end

    // Arbiter state; the hold registers remember the last word each master got.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wait_cnt       <= 4'd0;
            rd_owner       <= OWN_NONE;
            cpu_rdata_hold <= 16'h0000;
            dma_rdata_hold <= 16'h0000;
        end else begin
            wait_cnt <= wait_next;
            rd_owner <= owner_next;
            if (rd_owner == OWN_CPU) begin
                cpu_rdata_hold <= mem_rdata;
            end else begin
                cpu_rdata_hold <= cpu_rdata_hold;
            end
            if (rd_owner == OWN_DMA) begin
                dma_rdata_hold <= mem_rdata;
            end else begin
                dma_rdata_hold <= dma_rdata_hold;
            end
        end
    end

    // Memory data arrives the cycle after the strobe, so delivery is steered live.
    always_comb begin
        cpu_rvalid = (rd_owner == OWN_CPU);
        dma_rvalid = (rd_owner == OWN_DMA);
        if (cpu_rvalid) begin
            cpu_rdata = mem_rdata;
        end else begin
            cpu_rdata = cpu_rdata_hold;
        end
        if (dma_rvalid) begin
            dma_rdata = mem_rdata;
        end else begin
            dma_rdata = dma_rdata_hold;
        end
    end

endmodule

// File: tb/tb_mem_arbiter16.sv
// Randomised and directed bench for mem_arbiter16 against a behavioural
// model of the arbitration, starvation and read-return rules.
module tb_mem_arbiter16;

    localparam int WAIT_MAX = 3;

    logic        CLK;
    logic        RST;
    logic        cpu_req, cpu_wr, cpu_lock;
    logic [15:0] cpu_addr, cpu_wdata;
    logic        cpu_gnt, cpu_stall, cpu_rvalid;
    logic [15:0] cpu_rdata;
    logic        dma_req, dma_wr;
    logic [15:0] dma_addr, dma_wdata;
    logic        dma_gnt, dma_rvalid;
    logic [15:0] dma_rdata;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_OEb, mem_WRb;

    int vectors = 0;
    int miscompares = 0;
    logic checking = 1'b0;

    // Model state: consecutive denied DMA cycles, who gets the next read word
    // (0 none, 1 CPU, 2 DMA) and the last word each master received.
    int          m_wait;
    int          m_pending;
    logic [15:0] m_last_cpu;
    logic [15:0] m_last_dma;

    mem_arbiter16 #(.DMA_WAIT_MAX(WAIT_MAX)) dut (
        .CLK(CLK), .RST(RST),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_lock(cpu_lock),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall),
        .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_wr(dma_wr),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_OEb(mem_OEb), .mem_WRb(mem_WRb)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Returns {cpu_granted, dma_granted} from the arbitration rules.
    function automatic logic [1:0] exp_grants();
        bit dma_wins;
        if (cpu_req && dma_req) begin
            dma_wins = (m_wait >= WAIT_MAX) && !cpu_lock;
            return dma_wins ? 2'b01 : 2'b10;
        end
        return {cpu_req, dma_req};
    endfunction

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_wait     <= 0;
            m_pending  <= 0;
            m_last_cpu <= 16'h0000;
            m_last_dma <= 16'h0000;
        end else begin
            logic [1:0] g;
            g = exp_grants();
            if (m_pending == 1) m_last_cpu <= mem_rdata;
            if (m_pending == 2) m_last_dma <= mem_rdata;
            if (g[1] && !cpu_wr)      m_pending <= 1;
            else if (g[0] && !dma_wr) m_pending <= 2;
            else                      m_pending <= 0;
            if (dma_req && !g[0]) m_wait <= (m_wait >= 15) ? 15 : m_wait + 1;
            else                  m_wait <= 0;
        end
    end

    always @(negedge CLK) begin
        if (checking) begin
            logic [1:0]  g;
            logic [15:0] ea, ed;
            logic        rd, wr;
            g  = exp_grants();
            ea = g[1] ? cpu_addr  : (g[0] ? dma_addr  : 16'h0000);
            ed = g[1] ? cpu_wdata : (g[0] ? dma_wdata : 16'h0000);
            rd = (g[1] && !cpu_wr) || (g[0] && !dma_wr);
            wr = (g[1] && cpu_wr)  || (g[0] && dma_wr);
            cmp("cpu_gnt",    {15'd0, cpu_gnt},    {15'd0, g[1]});
            cmp("dma_gnt",    {15'd0, dma_gnt},    {15'd0, g[0]});
            cmp("cpu_stall",  {15'd0, cpu_stall},  {15'd0, cpu_req && !g[1]});
            cmp("mem_addr",   mem_addr,  ea);
            cmp("mem_wdata",  mem_wdata, ed);
            cmp("mem_OEb",    {15'd0, mem_OEb},    {15'd0, !rd});
            cmp("mem_WRb",    {15'd0, mem_WRb},    {15'd0, !wr});
            cmp("cpu_rvalid", {15'd0, cpu_rvalid}, {15'd0, m_pending == 1});
            cmp("dma_rvalid", {15'd0, dma_rvalid}, {15'd0, m_pending == 2});
            cmp("cpu_rdata",  cpu_rdata, (m_pending == 1) ? mem_rdata : m_last_cpu);
            cmp("dma_rdata",  dma_rdata, (m_pending == 2) ? mem_rdata : m_last_dma);
        end
    end

    task automatic drive(input logic cr, input logic cw, input logic cl, input logic [15:0] ca,
                         input logic [15:0] cd, input logic dr, input logic dw,
                         input logic [15:0] da, input logic [15:0] dd, input logic [15:0] md);
        @(posedge CLK);
        #1;
        cpu_req = cr; cpu_wr = cw; cpu_lock = cl; cpu_addr = ca; cpu_wdata = cd;
        dma_req = dr; dma_wr = dw; dma_addr = da; dma_wdata = dd; mem_rdata = md;
    endtask

    task automatic idle(input logic [15:0] md);
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, md);
    endtask

    initial begin
        RST = 1'b0;
        cpu_req = 1'b0; cpu_wr = 1'b0; cpu_lock = 1'b0; cpu_addr = 16'h0; cpu_wdata = 16'h0;
        dma_req = 1'b0; dma_wr = 1'b0; dma_addr = 16'h0; dma_wdata = 16'h0; mem_rdata = 16'h0;
        #2 RST = 1'b1;
        #1 checking = 1'b1;
        @(negedge CLK);
        cmp("reset_cpu_rvalid", {15'd0, cpu_rvalid}, 16'd0);
        cmp("reset_cpu_rdata", cpu_rdata, 16'h0000);
        cmp("reset_dma_rdata", dma_rdata, 16'h0000);
        @(posedge CLK);
        #1 RST = 1'b0;

        // CPU-only read returns tagged data next cycle
        drive(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h1111);
        @(negedge CLK);
        cmp("t1_cpu_gnt", {15'd0, cpu_gnt}, 16'd1);
        cmp("t1_oeb", {15'd0, mem_OEb}, 16'd0);
        cmp("t1_addr", mem_addr, 16'h0010);
        idle(16'hBEEF);
        @(negedge CLK);
        cmp("t1_rvalid", {15'd0, cpu_rvalid}, 16'd1);
        cmp("t1_rdata", cpu_rdata, 16'hBEEF);
        cmp("t1_dma_rvalid", {15'd0, dma_rvalid}, 16'd0);

        // DMA-only write, no read return
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 16'h8000, 16'h1234, 16'h0);
        @(negedge CLK);
        cmp("t2_dma_gnt", {15'd0, dma_gnt}, 16'd1);
        cmp("t2_wrb", {15'd0, mem_WRb}, 16'd0);
        cmp("t2_oeb", {15'd0, mem_OEb}, 16'd1);
        cmp("t2_addr", mem_addr, 16'h8000);
        cmp("t2_wdata", mem_wdata, 16'h1234);
        idle(16'h7777);
        @(negedge CLK);
        cmp("t2_dma_rvalid", {15'd0, dma_rvalid}, 16'd0);

        // Contention: CPU,CPU,CPU,DMA repeating
        for (int i = 0; i < 8; i++) begin
            logic e;
            e = (i % 4 == 3);
            drive(1'b1, 1'b0, 1'b0, 16'h0100, 16'h0, 1'b1, 1'b0, 16'h0200, 16'h0, 16'($urandom));
            @(negedge CLK);
            cmp("t3_dma_gnt", {15'd0, dma_gnt}, {15'd0, e});
            cmp("t3_cpu_stall", {15'd0, cpu_stall}, {15'd0, e});
        end

        // Lock holds off DMA; release with saturated counter forces DMA at once
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b0, 1'b1, 16'h0300, 16'h0, 1'b1, 1'b0, 16'h0400, 16'h0, 16'($urandom));
            @(negedge CLK);
            cmp("t4_lock_cpu_gnt", {15'd0, cpu_gnt}, 16'd1);
        end
        drive(1'b1, 1'b0, 1'b0, 16'h0300, 16'h0, 1'b1, 1'b0, 16'h0400, 16'h0, 16'h0);
        @(negedge CLK);
        cmp("t4_release_dma_gnt", {15'd0, dma_gnt}, 16'd1);
        drive(1'b1, 1'b0, 1'b0, 16'h0300, 16'h0, 1'b1, 1'b0, 16'h0400, 16'h0, 16'h0);
        @(negedge CLK);
        cmp("t4_after_cpu_gnt", {15'd0, cpu_gnt}, 16'd1);

        // Alternating single-master reads
        for (int i = 0; i < 7; i++) begin
            logic c;
            c = (i % 2 == 0);
            drive(c, 1'b0, 1'b0, 16'h0001, 16'h0, !c, 1'b0, 16'h0002, 16'h0, 16'hA000 + 16'(i));
            @(negedge CLK);
            cmp("t5_addr", mem_addr, c ? 16'h0001 : 16'h0002);
            if (i > 0) begin
                cmp("t5_cpu_rvalid", {15'd0, cpu_rvalid}, {15'd0, !c});
                cmp("t5_dma_rvalid", {15'd0, dma_rvalid}, {15'd0, c});
                if (c) cmp("t5_dma_rdata", dma_rdata, 16'hA000 + 16'(i));
                else   cmp("t5_cpu_rdata", cpu_rdata, 16'hA000 + 16'(i));
            end
        end

        // Reset pulse mid-cycle discards an outstanding CPU read
        drive(1'b1, 1'b0, 1'b0, 16'h0020, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
        idle(16'hDEAD);
        #2 RST = 1'b1;
        #1 RST = 1'b0;
        @(negedge CLK);
        cmp("t6_rvalid", {15'd0, cpu_rvalid}, 16'd0);
        cmp("t6_rdata", cpu_rdata, 16'h0000);
        drive(1'b1, 1'b0, 1'b0, 16'h0040, 16'h0, 1'b1, 1'b0, 16'h0050, 16'h0, 16'h0);
        @(negedge CLK);
        cmp("t6_cpu_first", {15'd0, cpu_gnt}, 16'd1);
        idle(16'h5A5A);
        @(negedge CLK);
        cmp("t6_post_rdata", cpu_rdata, 16'h5A5A);

        // Random traffic with occasional lock runs and reset pulses
        for (int i = 0; i < 600; i++) begin
            logic lk;
            lk = ((i / 25) % 3 == 2) && ($urandom_range(0, 7) != 0);
            drive($urandom_range(0, 3) != 0, 1'($urandom), lk, 16'($urandom), 16'($urandom),
                  $urandom_range(0, 2) != 0, 1'($urandom), 16'($urandom), 16'($urandom),
                  16'($urandom));
            if ($urandom_range(0, 99) == 0) begin
                #2 RST = 1'b1;
                #1 RST = 1'b0;
            end
        end

        @(negedge CLK);
        #1 checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
